// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//
// Turns the UART receiver's byte stream into tic-tac-toe commands:
//   "P<1..9>" + CR/LF -> MOVE (cell 0..8)
//   "N"       + CR/LF -> NEW
//   "S"       + CR/LF -> STATUS
// A bare CR/LF in idle is ignored. Malformed input, inter-byte timeouts inside a
// command and bytes arriving while a command is still pending are reported as
// one-cycle err pulses. err_code holds the last error code.
//
// Optional feature macro: UART_CMD_ECHO_EN
//   Defined:   accepted bytes are copied into a one-entry echo register toward the
//              transmitter (echo_valid/echo_data/echo_ready handshake).
//   Undefined: echo_valid and echo_data are tied to 0 and echo_ready is ignored.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   rx_rd, rx_data      receiver byte-ready level and byte
//   cmd_valid/ready     command handshake toward the game controller
//   cmd_op, cmd_cell    0 MOVE / 1 NEW / 2 STATUS; cell 0..8 for MOVE, else 0
//   err, err_code       error pulse; 1 BAD_OP 2 BAD_ARG 3 BAD_TERM 4 TIMEOUT 5 OVERRUN
//   echo_valid/data/ready  byte echo toward the transmitter

module uart_cmd_decoder #(
    parameter int unsigned SYS_CLK    = 14000000,
    parameter int unsigned TIMEOUT_MS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_rd,
    input  logic [7:0] rx_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [3:0] cmd_cell,
    output logic       err,
    output logic [2:0] err_code,
    output logic       echo_valid,
    output logic [7:0] echo_data,
    input  logic       echo_ready
);

    localparam logic [31:0] TIMEOUT_CYC = 32'((SYS_CLK / 1000) * TIMEOUT_MS);

    localparam logic [1:0] OpMove   = 2'd0;
    localparam logic [1:0] OpNew    = 2'd1;
    localparam logic [1:0] OpStatus = 2'd2;

    localparam logic [2:0] ErrBadOp   = 3'd1;
    localparam logic [2:0] ErrBadArg  = 3'd2;
    localparam logic [2:0] ErrBadTerm = 3'd3;
    localparam logic [2:0] ErrTimeout = 3'd4;
    localparam logic [2:0] ErrOverrun = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StArg,
        StTerm,
        StIssue
    } state_e;

    state_e      state_q, state_d;
    logic        rx_rd_q;             // rx_rd delayed one cycle for edge detection
    logic [1:0]  op_q, op_d;
    logic [3:0]  cell_q, cell_d;
    logic        err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    logic byte_ev;
    logic in_cmd;
    logic tmo_hit;
    logic handshake;
    logic is_term;
    logic is_digit;

    assign byte_ev   = rx_rd & ~rx_rd_q;
    assign in_cmd    = (state_q == StArg) || (state_q == StTerm);
    assign tmo_hit   = in_cmd && (tmo_cnt_q == TIMEOUT_CYC);
    assign handshake = (state_q == StIssue) && cmd_ready;
    assign is_term   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign is_digit  = (rx_data >= 8'h31) && (rx_data <= 8'h39);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cell_d     = cell_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        // Counter only runs inside a command; every byte restarts it, which also
        // covers entry to ARG/TERM since that only happens on a byte.
        if (byte_ev || !in_cmd) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (byte_ev) begin
                    if (rx_data == 8'h50) begin
                        state_d = StArg;
                        op_d    = OpMove;
                        cell_d  = '0;
                    end else if (rx_data == 8'h4E) begin
                        state_d = StTerm;
                        op_d    = OpNew;
                        cell_d  = '0;
                    end else if (rx_data == 8'h53) begin
                        state_d = StTerm;
                        op_d    = OpStatus;
                        cell_d  = '0;
                    end else if (!is_term) begin
                        err_d      = 1'b1;
                        err_code_d = ErrBadOp;
                        op_d       = '0;
                        cell_d     = '0;
                    end
                end
            end

            StArg: begin
                if (byte_ev) begin
                    if (is_digit) begin
                        state_d = StTerm;
                        // '1'..'9' have low nibble 1..9
                        cell_d  = rx_data[3:0] - 4'd1;
                    end else begin
                        state_d    = StIdle;
                        err_d      = 1'b1;
                        err_code_d = ErrBadArg;
                        op_d       = '0;
                        cell_d     = '0;
                    end
                end else if (tmo_hit) begin
                    state_d    = StIdle;
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                    op_d       = '0;
                    cell_d     = '0;
                end
            end

            StTerm: begin
                if (byte_ev) begin
                    if (is_term) begin
                        state_d = StIssue;
                    end else begin
                        state_d    = StIdle;
                        err_d      = 1'b1;
                        err_code_d = ErrBadTerm;
                        op_d       = '0;
                        cell_d     = '0;
                    end
                end else if (tmo_hit) begin
                    state_d    = StIdle;
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                    op_d       = '0;
                    cell_d     = '0;
                end
            end

            StIssue: begin
                if (handshake) begin
                    state_d = StIdle;
                end
                // The pending command is kept intact; the byte is simply lost.
                if (byte_ev) begin
                    err_d      = 1'b1;
                    err_code_d = ErrOverrun;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rx_rd_q    <= 1'b1;  // a level already high at reset release is not a byte
            op_q       <= '0;
            cell_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rx_rd_q    <= rx_rd;
            op_q       <= op_d;
            cell_q     <= cell_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign cmd_valid = (state_q == StIssue);
    assign cmd_op    = op_q;
    assign cmd_cell  = cell_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

`ifdef UART_CMD_ECHO_EN
    logic       echo_valid_q;
    logic [7:0] echo_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            echo_valid_q <= 1'b0;
            echo_data_q  <= '0;
        end else begin
            if (echo_valid_q && echo_ready) begin
                echo_valid_q <= 1'b0;
            end
            // Only an empty register accepts a byte; overrun bytes are never echoed.
            if (byte_ev && (state_q != StIssue) && !echo_valid_q) begin
                echo_valid_q <= 1'b1;
                echo_data_q  <= rx_data;
            end
        end
    end

    assign echo_valid = echo_valid_q;
    assign echo_data  = echo_data_q;
`else
    logic unused_echo_ready;
    assign unused_echo_ready = echo_ready;
    assign echo_valid        = 1'b0;
    assign echo_data         = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

    localparam int unsigned SYS_CLK    = 14000000;
    localparam int unsigned TIMEOUT_MS = 1;
    localparam int          TCYC       = 14000;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cell;
    logic       err;
    logic [2:0] err_code;
    logic       echo_valid;
    logic [7:0] echo_data;
    logic       echo_ready;

    int total = 0;
    int bad   = 0;

    // Snapshot taken one step after the edge that sees a byte event.
    logic       s_err, s_err_next, s_valid, s_echo_v;
    logic [2:0] s_code;
    logic [1:0] s_op;
    logic [3:0] s_cell;
    logic [7:0] s_echo_d;

    uart_cmd_decoder #(
        .SYS_CLK   (SYS_CLK),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_rd     (rx_rd),
        .rx_data   (rx_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cell  (cmd_cell),
        .err       (err),
        .err_code  (err_code),
        .echo_valid(echo_valid),
        .echo_data (echo_data),
        .echo_ready(echo_ready)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rd   = 1'b1;
        @(posedge clk);
        #1;
        s_err    = err;
        s_code   = err_code;
        s_valid  = cmd_valid;
        s_op     = cmd_op;
        s_cell   = cmd_cell;
        s_echo_v = echo_valid;
        s_echo_d = echo_data;
        @(posedge clk);
        #1;
        s_err_next = err;
        @(negedge clk);
        rx_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic handshake;
        @(negedge clk);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        s_valid = cmd_valid;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        rx_rd      = 1'b1;
        rx_data    = 8'h58;
        cmd_ready  = 1'b0;
        echo_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({cmd_valid, cmd_op, cmd_cell, err, err_code} !== 11'd0) begin
            bad++;
            $display("FAIL reset_cmd: got %b want 0", {cmd_valid, cmd_op, cmd_cell, err, err_code});
        end
        total++;
        if ({echo_valid, echo_data} !== 9'd0) begin
            bad++;
            $display("FAIL reset_echo: got %h want 0", {echo_valid, echo_data});
        end
        // rx_rd was high through reset: no event may be seen
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (err !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_event: err got %b want 0 (cycle %0d)", err, i);
            end
        end
        @(negedge clk);
        rx_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_move;
        logic [7:0] digs [3];
        logic [3:0] cells[3];
        digs[0] = 8'h35; cells[0] = 4'd4;
        digs[1] = 8'h31; cells[1] = 4'd0;
        digs[2] = 8'h39; cells[2] = 4'd8;
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h50);
            total++;
            if (s_valid !== 1'b0 || s_err !== 1'b0) begin
                bad++;
                $display("FAIL move_p_%0d: valid/err got %b%b want 00", k, s_valid, s_err);
            end
            send_byte(digs[k]);
            send_byte((k == 2) ? 8'h0A : 8'h0D);
            total++;
            if ({s_valid, s_op, s_cell, s_err} !== {1'b1, 2'd0, cells[k], 1'b0}) begin
                bad++;
                $display("FAIL move_cmd_%0d: got v=%b op=%0d cell=%0d err=%b want v=1 op=0 cell=%0d err=0",
                         k, s_valid, s_op, s_cell, s_err, cells[k]);
            end
            if (k == 0) begin
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #1;
                    total++;
                    if ({cmd_valid, cmd_op, cmd_cell} !== {1'b1, 2'd0, 4'd4}) begin
                        bad++;
                        $display("FAIL move_hold_%0d: got v=%b op=%0d cell=%0d want v=1 op=0 cell=4",
                                 i, cmd_valid, cmd_op, cmd_cell);
                    end
                end
            end
            handshake();
            total++;
            if (s_valid !== 1'b0) begin
                bad++;
                $display("FAIL move_hs_%0d: cmd_valid got %b want 0", k, s_valid);
            end
        end
    endtask

    task automatic test_bad_op;
        send_byte(8'h58);
        total++;
        if ({s_err, s_code, s_valid} !== {1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL bad_op: got err=%b code=%0d v=%b want err=1 code=1 v=0", s_err, s_code, s_valid);
        end
        total++;
        if (s_err_next !== 1'b0 || err_code !== 3'd1) begin
            bad++;
            $display("FAIL bad_op_pulse: err next got %b code %0d want 0 / 1", s_err_next, err_code);
        end
        send_byte(8'h4E);
        send_byte(8'h0A);
        total++;
        if ({s_valid, s_op, s_cell} !== {1'b1, 2'd1, 4'd0}) begin
            bad++;
            $display("FAIL new_cmd: got v=%b op=%0d cell=%0d want v=1 op=1 cell=0", s_valid, s_op, s_cell);
        end
        handshake();
        // lowercase is not a command letter
        send_byte(8'h70);
        total++;
        if ({s_err, s_code} !== {1'b1, 3'd1}) begin
            bad++;
            $display("FAIL lower_p: got err=%b code=%0d want err=1 code=1", s_err, s_code);
        end
    endtask

    task automatic test_bad_arg_term;
        send_byte(8'h50);
        send_byte(8'h30);
        total++;
        if ({s_err, s_code, s_op, s_cell} !== {1'b1, 3'd2, 2'd0, 4'd0}) begin
            bad++;
            $display("FAIL bad_arg: got err=%b code=%0d op=%0d cell=%0d want 1/2/0/0", s_err, s_code, s_op, s_cell);
        end
        send_byte(8'h53);
        send_byte(8'h51);
        total++;
        if ({s_err, s_code, s_op} !== {1'b1, 3'd3, 2'd0}) begin
            bad++;
            $display("FAIL bad_term: got err=%b code=%0d op=%0d want 1/3/0", s_err, s_code, s_op);
        end
        send_byte(8'h0D);
        total++;
        if ({s_err, s_valid, s_code} !== {1'b0, 1'b0, 3'd3}) begin
            bad++;
            $display("FAIL idle_cr: got err=%b v=%b code=%0d want 0/0/3", s_err, s_valid, s_code);
        end
    endtask

    task automatic test_timeout;
        int  k;
        logic seen;
        @(negedge clk);
        rx_data = 8'h50;
        rx_rd   = 1'b1;
        @(posedge clk);
        #1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < TCYC + 100) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 2) rx_rd = 1'b0;
            if (err === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || k != TCYC + 1) begin
            bad++;
            $display("FAIL timeout_latency: got seen=%b cycles=%0d want seen=1 cycles=%0d", seen, k, TCYC + 1);
        end
        total++;
        if ({err_code, cmd_op, cmd_cell, cmd_valid} !== {3'd4, 2'd0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL timeout_code: got code=%0d op=%0d cell=%0d v=%b want 4/0/0/0",
                     err_code, cmd_op, cmd_cell, cmd_valid);
        end
        send_byte(8'h37);
        total++;
        if ({s_err, s_code} !== {1'b1, 3'd1}) begin
            bad++;
            $display("FAIL timeout_then_7: got err=%b code=%0d want 1/1", s_err, s_code);
        end
        send_byte(8'h0D);
        total++;
        if ({s_err, s_valid} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_then_cr: got err=%b v=%b want 0/0", s_err, s_valid);
        end
    endtask

    task automatic test_overrun;
        int n_err;
        send_byte(8'h50);
        send_byte(8'h32);
        send_byte(8'h0D);
        // rx_rd held high 1000 cycles while a MOVE is pending
        @(negedge clk);
        rx_data = 8'h53;
        rx_rd   = 1'b1;
        n_err   = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (err === 1'b1) n_err++;
            if (i == 0) begin
                total++;
                if ({err, err_code} !== {1'b1, 3'd5}) begin
                    bad++;
                    $display("FAIL overrun_code: got err=%b code=%0d want 1/5", err, err_code);
                end
            end
        end
        total++;
        if (n_err != 1) begin
            bad++;
            $display("FAIL overrun_one_event: got %0d err pulses want 1", n_err);
        end
        total++;
        if ({cmd_valid, cmd_op, cmd_cell} !== {1'b1, 2'd0, 4'd1}) begin
            bad++;
            $display("FAIL overrun_pending: got v=%b op=%0d cell=%0d want 1/0/1", cmd_valid, cmd_op, cmd_cell);
        end
        @(negedge clk);
        rx_rd = 1'b0;
        handshake();
        // overrun in the same cycle as the handshake
        send_byte(8'h58);
        send_byte(8'h50);
        send_byte(8'h34);
        send_byte(8'h0D);
        @(negedge clk);
        rx_data   = 8'h53;
        rx_rd     = 1'b1;
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({err, err_code, cmd_valid} !== {1'b1, 3'd5, 1'b0}) begin
            bad++;
            $display("FAIL overrun_hs: got err=%b code=%0d v=%b want 1/5/0", err, err_code, cmd_valid);
        end
        @(negedge clk);
        cmd_ready = 1'b0;
        rx_rd     = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_echo;
        logic [7:0] seq[3];
        seq[0] = 8'h50; seq[1] = 8'h33; seq[2] = 8'h0D;
        echo_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i]);
`ifdef UART_CMD_ECHO_EN
            total++;
            if ({s_echo_v, s_echo_d} !== {1'b1, seq[i]}) begin
                bad++;
                $display("FAIL echo_seq_%0d: got v=%b d=%h want v=1 d=%h", i, s_echo_v, s_echo_d, seq[i]);
            end
`else
            total++;
            if ({s_echo_v, s_echo_d} !== 9'd0) begin
                bad++;
                $display("FAIL echo_off_%0d: got v=%b d=%h want 0/00", i, s_echo_v, s_echo_d);
            end
`endif
        end
        handshake();
        echo_ready = 1'b0;
        send_byte(8'h4E);
        send_byte(8'h0A);
`ifdef UART_CMD_ECHO_EN
        total++;
        if ({s_echo_v, s_echo_d} !== {1'b1, 8'h4E}) begin
            bad++;
            $display("FAIL echo_full: got v=%b d=%h want v=1 d=4e", s_echo_v, s_echo_d);
        end
`else
        total++;
        if ({s_echo_v, s_echo_d} !== 9'd0) begin
            bad++;
            $display("FAIL echo_off_full: got v=%b d=%h want 0/00", s_echo_v, s_echo_d);
        end
`endif
        total++;
        if ({s_valid, s_op} !== {1'b1, 2'd1}) begin
            bad++;
            $display("FAIL echo_parse: got v=%b op=%0d want 1/1", s_valid, s_op);
        end
        handshake();
        echo_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (echo_valid !== 1'b0) begin
            bad++;
            $display("FAIL echo_clear: got %b want 0", echo_valid);
        end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h50);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({cmd_valid, cmd_op, cmd_cell, err, err_code, echo_valid, echo_data} !== 20'd0) begin
            bad++;
            $display("FAIL reset_arg: got %h want 0",
                     {cmd_valid, cmd_op, cmd_cell, err, err_code, echo_valid, echo_data});
        end
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h0D);
        total++;
        if ({s_err, s_valid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_arg_idle: got err=%b v=%b want 0/0", s_err, s_valid);
        end
        send_byte(8'h53);
        send_byte(8'h0D);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({cmd_valid, err} !== 2'b00) begin
            bad++;
            $display("FAIL reset_issue: got v=%b err=%b want 0/0", cmd_valid, err);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({cmd_valid, err} !== 2'b00) begin
            bad++;
            $display("FAIL reset_issue_after: got v=%b err=%b want 0/0", cmd_valid, err);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_bad_op();
        test_bad_arg_term();
        test_timeout();
        test_overrun();
        test_echo();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
